plab3_mem_line_to_word_adapter: RTL and testbench

- Sits directly downstream of the blocking L1 cache datapath/control, on its memory port.
- Accepts one 128-bit cacheline memory request and serializes it into four 32-bit word requests to a word-wide memory.
- Collects the four word responses, reassembles them into one cacheline memory response, and returns it to the cache.
- Latches the security domain with each line transaction and tags every downstream word request with it.

---
 rtl/plab3_mem_line_to_word_adapter_if.sv | 29 ++
 rtl/plab3_mem_line_to_word_adapter.sv | 191 +++++++++++++++++++
 tb/tb_plab3_mem_line_to_word_adapter.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/plab3_mem_line_to_word_adapter_if.sv
// ----------------------------------------------------------------------------
// plab3_mem_line_to_word_adapter_if
//
// Purpose: one val/rdy/msg channel. The adapter uses four of these: the line
// request and line response channels facing the cache, and the word request
// and word response channels facing the word-wide memory.
//
// Parameters:
//   p_msg_nbits  width of the message carried on the channel
//
// Signals:
//   val  producer has a message this cycle (never depends on rdy)
//   rdy  consumer can take the message this cycle
//   msg  message payload, held stable while val is high and rdy is low
//
// Modports:
//   master  producer side (drives val/msg, observes rdy)
//   slave   consumer side (observes val/msg, drives rdy)
// ----------------------------------------------------------------------------
interface plab3_mem_line_to_word_adapter_if #(
    parameter int p_msg_nbits = 8
);
    logic                   val;
    logic                   rdy;
    logic [p_msg_nbits-1:0] msg;

    modport master (output val, output msg, input rdy);
    modport slave  (input val, input msg, output rdy);
endinterface

// File: rtl/plab3_mem_line_to_word_adapter.sv
// ----------------------------------------------------------------------------
// plab3_mem_line_to_word_adapter
//
// Purpose: takes one cacheline memory request from the blocking L1 cache,
// splits it into four word requests to a word-wide memory, gathers the four
// in-order word responses back into a cacheline and returns a single line
// response. The requester's security domain is captured with each line
// transaction and presented on cur_domain for the word-side traffic.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous reset, active low (asserted when 0)
//   domain      requester security domain, sampled on line request accept
//   linereq     slave  : {type, opaque, addr, len, data}    3+o+abw+4+clw
//   lineresp    master : {type, opaque, len, data}          3+o+4+clw
//   wordreq     master : {type, opaque, addr, len, data}    3+o+abw+2+dbw
//   wordresp    slave  : {type, opaque, len, data}          3+o+2+dbw
//   cur_domain  domain latched for the in-flight transaction
// ----------------------------------------------------------------------------
module plab3_mem_line_to_word_adapter #(
    parameter int p_opaque_nbits = 8,
    parameter int p_addr_nbits   = 32,
    parameter int p_word_nbits   = 32,
    parameter int p_line_nbits   = 128
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    domain,
    plab3_mem_line_to_word_adapter_if.slave         linereq,
    plab3_mem_line_to_word_adapter_if.master        lineresp,
    plab3_mem_line_to_word_adapter_if.master        wordreq,
    plab3_mem_line_to_word_adapter_if.slave         wordresp,
    output logic                                    cur_domain
);

    localparam int c_o   = p_opaque_nbits;
    localparam int c_abw = p_addr_nbits;
    localparam int c_dbw = p_word_nbits;
    localparam int c_clw = p_line_nbits;

    localparam int c_wresp_nbits = 3 + c_o + 2 + c_dbw;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t               state_q,     state_d;
    logic [2:0]           type_q,      type_d;
    logic [c_o-1:0]       opaque_q,    opaque_d;
    logic [c_abw-5:0]     line_addr_q, line_addr_d;
    logic [c_clw-1:0]     data_q,      data_d;
    logic [c_clw-1:0]     buf_q,       buf_d;
    logic                 domain_q,    domain_d;
    logic [2:0]           issue_cnt_q, issue_cnt_d;
    logic [2:0]           resp_cnt_q,  resp_cnt_d;

    logic [2:0]           lreq_type;
    logic [c_o-1:0]       lreq_opaque;
    logic [c_abw-1:0]     lreq_addr;
    logic [c_clw-1:0]     lreq_data;
    logic [c_dbw-1:0]     wresp_data;
    logic [2:0]           word_type;
    logic [c_o-1:0]       word_opaque;
    logic                 unused_bits;

    assign lreq_type   = linereq.msg[c_clw+4+c_abw+c_o +: 3];
    assign lreq_opaque = linereq.msg[c_clw+4+c_abw +: c_o];
    assign lreq_addr   = linereq.msg[c_clw+4 +: c_abw];
    assign lreq_data   = linereq.msg[c_clw-1:0];
    assign wresp_data  = wordresp.msg[c_dbw-1:0];

    // The line length, the byte offset of the line address and the
    // non-data fields of word responses carry no information here.
    assign unused_bits = ^{lreq_addr[3:0], linereq.msg[c_clw+3:c_clw],
                           wordresp.msg[c_wresp_nbits-1:c_dbw]};

    // Init requests write the whole line, so the word memory only ever
    // sees reads (0) and writes (1).
    assign word_type   = ((type_q == 3'd1) || (type_q == 3'd2)) ? 3'd1 : 3'd0;

    // Each word request carries its word index as opaque so the memory
    // side can be traced back to the line position.
    assign word_opaque = c_o'(issue_cnt_q[1:0]);

    assign cur_domain  = domain_q;

    // State register and all latched transaction fields. Reset clears
    // everything, including the response buffer, so nothing survives it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            type_q      <= '0;
            opaque_q    <= '0;
            line_addr_q <= '0;
            data_q      <= '0;
            buf_q       <= '0;
            domain_q    <= 1'b0;
            issue_cnt_q <= '0;
            resp_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            opaque_q    <= opaque_d;
            line_addr_q <= line_addr_d;
            data_q      <= data_d;
            buf_q       <= buf_d;
            domain_q    <= domain_d;
            issue_cnt_q <= issue_cnt_d;
            resp_cnt_q  <= resp_cnt_d;
        end
    end

    // Next-state and handshake logic. Word requests are issued while fewer
    // than four have gone out; a word response is only taken when one is
    // outstanding, which keeps the response index in step with the issue
    // index without any extra tracking.
    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        opaque_d    = opaque_q;
        line_addr_d = line_addr_q;
        data_d      = data_q;
        buf_d       = buf_q;
        domain_d    = domain_q;
        issue_cnt_d = issue_cnt_q;
        resp_cnt_d  = resp_cnt_q;

        linereq.rdy  = 1'b0;
        wordreq.val  = 1'b0;
        wordresp.rdy = 1'b0;
        lineresp.val = 1'b0;

        wordreq.msg  = {word_type, word_opaque,
                        line_addr_q, issue_cnt_q[1:0], 2'b00,
                        2'b00,
                        data_q[c_dbw*issue_cnt_q[1:0] +: c_dbw]};
        lineresp.msg = {type_q, opaque_q, 4'd0, buf_q};

        case (state_q)
            IDLE: begin
                // Held low while reset is asserted so the cache sees no
                // acceptance window until reset is released.
                linereq.rdy = reset;
                if (linereq.val && reset) begin
                    type_d      = lreq_type;
                    opaque_d    = lreq_opaque;
                    line_addr_d = lreq_addr[c_abw-1:4];
                    data_d      = lreq_data;
                    domain_d    = domain;
                    buf_d       = '0;
                    issue_cnt_d = 3'd0;
                    resp_cnt_d  = 3'd0;
                    state_d     = XFER;
                end
            end

            XFER: begin
                wordreq.val  = (issue_cnt_q < 3'd4);
                wordresp.rdy = (resp_cnt_q < issue_cnt_q);
                if ((issue_cnt_q < 3'd4) && wordreq.rdy) begin
                    issue_cnt_d = issue_cnt_q + 3'd1;
                end
                if ((resp_cnt_q < issue_cnt_q) && wordresp.val) begin
                    // Write acknowledgements carry no data; leaving the
                    // zeroed buffer untouched makes the line response data 0.
                    if (word_type == 3'd0) begin
                        buf_d[c_dbw*resp_cnt_q[1:0] +: c_dbw] = wresp_data;
                    end
                    resp_cnt_d = resp_cnt_q + 3'd1;
                    if (resp_cnt_q == 3'd3) begin
                        state_d = RESP;
                    end
                end
            end

            RESP: begin
                lineresp.val = 1'b1;
                if (lineresp.rdy) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_plab3_mem_line_to_word_adapter.sv
// ----------------------------------------------------------------------------
// tb_plab3_mem_line_to_word_adapter
//
// Directed bench for the line-to-word adapter. A small word-memory model
// answers word requests in order after a configurable delay; the main
// sequence drives line requests and checks word traffic, line responses,
// handshakes, reset behaviour and domain latching.
// ----------------------------------------------------------------------------
module tb_plab3_mem_line_to_word_adapter;

    localparam int LREQ_W  = 175;
    localparam int LRESP_W = 143;
    localparam int WREQ_W  = 77;
    localparam int WRESP_W = 45;

    typedef struct {
        int                 ready;
        logic [WRESP_W-1:0] msg;
    } pend_t;

    logic clk;
    logic reset;
    logic domain;
    logic cur_domain;

    plab3_mem_line_to_word_adapter_if #(.p_msg_nbits(LREQ_W))  linereq_if ();
    plab3_mem_line_to_word_adapter_if #(.p_msg_nbits(LRESP_W)) lineresp_if ();
    plab3_mem_line_to_word_adapter_if #(.p_msg_nbits(WREQ_W))  wordreq_if ();
    plab3_mem_line_to_word_adapter_if #(.p_msg_nbits(WRESP_W)) wordresp_if ();

    logic               model_val;
    logic [WRESP_W-1:0] model_msg;
    logic               stray_val;
    logic [WRESP_W-1:0] stray_msg;

    pend_t              pend [$];
    logic [WREQ_W-1:0]  req_log [$];
    logic [31:0]        mem_words [4];
    int                 lat;
    int                 req_fires;
    int                 resp_fires;

    int                 total;
    int                 bad;
    bit                 toggle_mode;
    logic               prev_stall;
    logic [WREQ_W-1:0]  prev_wmsg;

    assign wordresp_if.val = model_val | stray_val;
    assign wordresp_if.msg = stray_val ? stray_msg : model_msg;

    plab3_mem_line_to_word_adapter dut (
        .clk        (clk),
        .reset      (reset),
        .domain     (domain),
        .linereq    (linereq_if),
        .lineresp   (lineresp_if),
        .wordreq    (wordreq_if),
        .wordresp   (wordresp_if),
        .cur_domain (cur_domain)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Word memory model: handshakes are sampled on the falling edge (what
    // the next rising edge will see) and the model updates 1 time unit
    // after the rising edge. Responses come back in request order, each
    // becoming valid lat cycles after the cycle following its request.
    initial begin
        logic              rf;
        logic              sf;
        logic [WREQ_W-1:0] rmsg;
        logic [2:0]        rtype;
        logic [31:0]       raddr;
        logic [31:0]       rdata;
        pend_t             p;
        int                cyc;
        cyc        = 0;
        model_val  = 1'b0;
        model_msg  = '0;
        req_fires  = 0;
        resp_fires = 0;
        forever begin
            @(negedge clk);
            rf   = wordreq_if.val && wordreq_if.rdy;
            sf   = wordresp_if.val && wordresp_if.rdy;
            rmsg = wordreq_if.msg;
            @(posedge clk);
            #1;
            cyc++;
            if (!reset) begin
                pend.delete();
                model_val  = 1'b0;
                req_fires  = 0;
                resp_fires = 0;
            end else begin
                if (sf && (pend.size() > 0)) begin
                    void'(pend.pop_front());
                    resp_fires++;
                end
                if (rf) begin
                    req_log.push_back(rmsg);
                    req_fires++;
                    rtype   = rmsg[76:74];
                    raddr   = rmsg[65:34];
                    rdata   = (rtype == 3'd0) ? mem_words[raddr[3:2]] : 32'hDEADBEEF;
                    p.ready = cyc + lat;
                    p.msg   = {rtype, rmsg[73:66], 2'b00, rdata};
                    pend.push_back(p);
                end
                if ((pend.size() > 0) && (pend[0].ready <= cyc)) begin
                    model_val = 1'b1;
                    model_msg = pend[0].msg;
                end else begin
                    model_val = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [191:0] obs,
                                input logic [191:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Advance one cycle; the response-ready and stall-stability checks run
    // on every cycle the bench spends with reset released.
    task automatic step();
        @(posedge clk);
        #2;
        if (reset) begin
            check_output("wordresp_rdy_vs_outstanding", wordresp_if.rdy,
                         (req_fires - resp_fires) > 0);
            if (prev_stall) begin
                check_output("wordreq_stall_val", wordreq_if.val, 1'b1);
                check_output("wordreq_stall_msg", wordreq_if.msg, prev_wmsg);
            end
        end
        if (toggle_mode) wordreq_if.rdy = ~wordreq_if.rdy;
        prev_stall = reset && wordreq_if.val && !wordreq_if.rdy;
        prev_wmsg  = wordreq_if.msg;
    endtask

    function automatic logic [WREQ_W-1:0] exp_wreq(input logic [2:0] t, input int i,
                                                   input logic [31:0] addr,
                                                   input logic [127:0] data);
        logic [2:0]  wt;
        logic [31:0] wa;
        wt = ((t == 3'd1) || (t == 3'd2)) ? 3'd1 : 3'd0;
        wa = {addr[31:4], 2'(i), 2'b00};
        return {wt, 8'(i), wa, 2'b00, data[32*i +: 32]};
    endfunction

    task automatic send_line(input logic [2:0] t, input logic [7:0] opq,
                             input logic [31:0] addr, input logic [127:0] data,
                             input logic dom);
        logic acc;
        acc = 1'b0;
        domain = dom;
        linereq_if.msg = {t, opq, addr, 4'd0, data};
        linereq_if.val = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = linereq_if.rdy;
            step();
        end
        linereq_if.val = 1'b0;
        check_output("linereq_accept", acc, 1'b1);
    endtask

    task automatic run_line(input string tag, input logic [2:0] t, input logic [7:0] opq,
                            input logic [31:0] addr, input logic [127:0] data,
                            input logic dom, input bit flip, input int hold,
                            input logic [127:0] exp_data, output int cycles);
        int                 base;
        int                 n;
        logic               seen;
        logic [LRESP_W-1:0] exp_resp;
        base = req_log.size();
        lineresp_if.rdy = 1'b0;
        send_line(t, opq, addr, data, dom);
        if (flip) domain = ~dom;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            check_output({tag, "_cur_domain"}, cur_domain, dom);
            seen = lineresp_if.val;
            if (!seen) begin
                step();
                n++;
            end
        end
        check_output({tag, "_lineresp_seen"}, seen, 1'b1);
        exp_resp = {t, opq, 4'd0, exp_data};
        check_output({tag, "_lineresp_msg"}, lineresp_if.msg, exp_resp);
        for (int h = 0; h < hold; h++) begin
            step();
            check_output({tag, "_hold_val"}, lineresp_if.val, 1'b1);
            check_output({tag, "_hold_msg"}, lineresp_if.msg, exp_resp);
            check_output({tag, "_hold_linereq_rdy"}, linereq_if.rdy, 1'b0);
        end
        lineresp_if.rdy = 1'b1;
        check_output({tag, "_no_same_cycle_accept"}, linereq_if.rdy, 1'b0);
        step();
        lineresp_if.rdy = 1'b0;
        check_output({tag, "_lineresp_done"}, lineresp_if.val, 1'b0);
        check_output({tag, "_back_idle"}, linereq_if.rdy, 1'b1);
        check_output({tag, "_word_count"}, req_log.size() - base, 4);
        for (int i = 0; i < 4; i++) begin
            if (base + i < req_log.size())
                check_output({tag, "_wordreq"}, req_log[base+i], exp_wreq(t, i, addr, data));
        end
        cycles = n;
    endtask

    initial begin
        int cycles;
        int base;
        total       = 0;
        bad         = 0;
        toggle_mode = 1'b0;
        prev_stall  = 1'b0;
        prev_wmsg   = '0;
        reset       = 1'b0;
        domain      = 1'b0;
        stray_val   = 1'b0;
        stray_msg   = '0;
        lat         = 0;
        linereq_if.val  = 1'b0;
        linereq_if.msg  = '0;
        lineresp_if.rdy = 1'b0;
        wordreq_if.rdy  = 1'b1;
        mem_words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

        // Reset state
        #1;
        check_output("rst_linereq_rdy", linereq_if.rdy, 1'b0);
        check_output("rst_wordreq_val", wordreq_if.val, 1'b0);
        check_output("rst_lineresp_val", lineresp_if.val, 1'b0);
        check_output("rst_cur_domain", cur_domain, 1'b0);
        step();
        step();
        reset = 1'b1;
        #1;
        check_output("rst_release_linereq_rdy", linereq_if.rdy, 1'b1);

        // 1: line read with zero-delay memory, latency check
        $display("[TB] line read");
        run_line("read", 3'd0, 8'h5A, 32'h0000_1234, 128'h0, 1'b1, 1'b0, 0,
                 128'h44444444_33333333_22222222_11111111, cycles);
        check_output("read_latency", cycles, 5);

        // 2: line write; buffer must not carry the previous read data
        $display("[TB] line write");
        run_line("write", 3'd1, 8'h33, 32'h0000_0100,
                 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 1'b0, 1'b0, 0, 128'h0, cycles);
        run_line("init", 3'd2, 8'h07, 32'h0000_5008,
                 128'h01234567_89ABCDEF_FEDCBA98_76543210, 1'b1, 1'b0, 0, 128'h0, cycles);

        // 3: word request backpressure and line response stall
        $display("[TB] backpressure");
        mem_words = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
        toggle_mode = 1'b1;
        run_line("bp", 3'd0, 8'h12, 32'h0000_2220, 128'h0, 1'b0, 1'b0, 3,
                 128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0, cycles);
        toggle_mode    = 1'b0;
        wordreq_if.rdy = 1'b1;

        // 4: responses three cycles late, requests pipelined
        $display("[TB] late responses");
        lat = 3;
        mem_words = '{32'h0BADF00D, 32'hCAFEBABE, 32'h12345678, 32'h9ABCDEF0};
        run_line("late", 3'd0, 8'h21, 32'h0000_4440, 128'h0, 1'b1, 1'b0, 0,
                 128'h9ABCDEF0_12345678_CAFEBABE_0BADF00D, cycles);

        // 5: reset after the second word request of a read
        $display("[TB] reset mid-transfer");
        base = req_log.size();
        send_line(3'd0, 8'h77, 32'h0000_0300, 128'h0, 1'b1);
        for (int i = 0; i < 20 && (req_log.size() - base) < 2; i++) step();
        check_output("mid_two_requests", req_log.size() - base, 2);
        reset = 1'b0;
        #1;
        check_output("mid_rst_linereq_rdy", linereq_if.rdy, 1'b0);
        check_output("mid_rst_wordreq_val", wordreq_if.val, 1'b0);
        check_output("mid_rst_wordresp_rdy", wordresp_if.rdy, 1'b0);
        check_output("mid_rst_lineresp_val", lineresp_if.val, 1'b0);
        check_output("mid_rst_cur_domain", cur_domain, 1'b0);
        check_output("mid_rst_wordreq_msg", wordreq_if.msg, 77'h0);
        check_output("mid_rst_lineresp_msg", lineresp_if.msg, 143'h0);
        step();
        step();
        reset = 1'b1;
        #1;
        check_output("mid_release_linereq_rdy", linereq_if.rdy, 1'b1);
        lat = 0;
        mem_words = '{32'h0A0A0A0A, 32'h1B1B1B1B, 32'h2C2C2C2C, 32'h3D3D3D3D};
        run_line("after_rst", 3'd0, 8'h44, 32'h0000_0200, 128'h0, 1'b0, 1'b0, 0,
                 128'h3D3D3D3D_2C2C2C2C_1B1B1B1B_0A0A0A0A, cycles);

        // 6: domain flip mid-transfer, then a stray response in IDLE
        $display("[TB] domain hold and stray response");
        lat = 1;
        run_line("dom", 3'd0, 8'h66, 32'h0000_6600, 128'h0, 1'b1, 1'b1, 0,
                 128'h3D3D3D3D_2C2C2C2C_1B1B1B1B_0A0A0A0A, cycles);
        stray_msg = {3'd0, 8'h03, 2'b00, 32'hBAD0BAD0};
        stray_val = 1'b1;
        step();
        check_output("stray_wordresp_rdy", wordresp_if.rdy, 1'b0);
        check_output("stray_linereq_rdy", linereq_if.rdy, 1'b1);
        check_output("stray_wordreq_val", wordreq_if.val, 1'b0);
        check_output("stray_lineresp_val", lineresp_if.val, 1'b0);
        check_output("stray_cur_domain", cur_domain, 1'b1);
        step();
        stray_val = 1'b0;
        mem_words = '{32'h50505050, 32'h61616161, 32'h72727272, 32'h83838383};
        run_line("post_stray", 3'd0, 8'h99, 32'h0000_7770, 128'h0, 1'b0, 1'b0, 0,
                 128'h83838383_72727272_61616161_50505050, cycles);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
